// File: rtl/imem_boot_sequencer.sv
// Purpose: boot loader that holds the MIPS core in reset, streams a length-prefixed
//          big-endian byte program into instruction memory, then releases the core.
// Latency: one write strobe in the cycle after each word's 4th byte; the core is released
//          after RST_HOLD cycles counted from the cycle following the final write.
// Backpressure: byte_ready is registered and high only while a length or payload byte
//          is wanted; bytes are taken back-to-back, including during a write cycle.
// Ports:
//   CLK, RST             clock, async active-high reset
//   start                pulse; starts a load session from IDLE or RUN
//   byte_valid/_data     incoming byte stream, byte_ready is the accept handshake
//   imem_we/addr/wdata   instruction-memory write port
//   core_rst             core reset (high until the program is loaded and the hold expires)
//   busy, done, err      session status; err is sticky until the next accepted start
module imem_boot_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int RST_HOLD = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, LOAD, HOLD, RUN} seqState;

  // 17-bit arithmetic so a length of exactly 2^ADDR_W never wraps the word counter.
  localparam logic [16:0] CAPACITY  = 17'd1 << ADDR_W;
  localparam logic [3:0]  HOLD_LAST = 4'(RST_HOLD - 1);

  seqState     state, stateNext;
  logic [15:0] lenReg, lenNext;
  logic [1:0]  byteCnt, byteCntNext;
  logic [23:0] asmReg, asmNext;         // first three bytes of the word being assembled
  logic [16:0] wordCnt, wordCntNext;
  logic [3:0]  holdCnt, holdCntNext;
  logic        weNext, errNext;
  logic [ADDR_W-1:0] addrNext;
  logic [31:0] wdataNext;
  logic        xfer;

  assign xfer = byte_valid && byte_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    lenNext     = lenReg;
    byteCntNext = byteCnt;
    asmNext     = asmReg;
    wordCntNext = wordCnt;
    holdCntNext = holdCnt;
    weNext      = 1'b0;
    addrNext    = imem_addr;
    wdataNext   = imem_wdata;
    errNext     = err;
    case (state)
      IDLE, RUN: begin
        if (start) begin
          stateNext   = LEN_HI;
          lenNext     = '0;
          byteCntNext = '0;
          wordCntNext = '0;
          holdCntNext = '0;
          errNext     = 1'b0;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          lenNext[15:8] = byte_data;
          stateNext     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          lenNext[7:0] = byte_data;
          if (lenNext == 16'd0) begin
            stateNext = HOLD;
          end else if ({1'b0, lenNext} > CAPACITY) begin
            stateNext = IDLE;
            errNext   = 1'b1;
          end else begin
            stateNext = LOAD;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          byteCntNext = byteCnt + 2'd1;
          if (byteCnt == 2'd3) begin
            weNext      = 1'b1;
            addrNext    = wordCnt[ADDR_W-1:0];
            wdataNext   = {asmReg, byte_data};
            wordCntNext = wordCnt + 17'd1;
            // Leave on the last byte so byte_ready is already low during the final write.
            if (wordCntNext == {1'b0, lenReg}) stateNext = HOLD;
          end else begin
            asmNext = {asmReg[15:0], byte_data};
          end
        end
      end
      HOLD: begin
        // The final write cycle itself is not part of the hold interval.
        if (!imem_we) begin
          if (holdCnt == HOLD_LAST) stateNext = RUN;
          else                      holdCntNext = holdCnt + 4'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lenReg     <= '0;
      byteCnt    <= '0;
      asmReg     <= '0;
      wordCnt    <= '0;
      holdCnt    <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      lenReg     <= lenNext;
      byteCnt    <= byteCntNext;
      asmReg     <= asmNext;
      wordCnt    <= wordCntNext;
      holdCnt    <= holdCntNext;
      imem_we    <= weNext;
      imem_addr  <= addrNext;
      imem_wdata <= wdataNext;
      err        <= errNext;
      // Status outputs are registered copies of the state being entered.
      byte_ready <= stateNext inside {LEN_HI, LEN_LO, LOAD};
      busy       <= stateNext inside {LEN_HI, LEN_LO, LOAD, HOLD};
      core_rst   <= (stateNext != RUN);
      done       <= (stateNext == RUN);
    end
  end

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Testbench for imem_boot_sequencer: table of load sessions, hand-written reset and
// start-during-load sequences, then random sessions checked against a byte-stream model.
module tb_imem_boot_sequencer;

  localparam int ADDR_W   = 8;
  localparam int RST_HOLD = 4;
  localparam int CAP      = 1 << ADDR_W;

  logic              CLK = 1'b0;
  logic              RST;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              err;

  imem_boot_sequencer #(.ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD)) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int nCmp = 0;
  int nBad = 0;

  logic [7:0]        stream[$];
  logic [ADDR_W-1:0] gotAddr[$];
  logic [31:0]       gotData[$];
  int                gotCyc[$];
  int                lastXfer;
  logic [7:0]        fixedBytes [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

  // Write-port monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (!RST && imem_we) begin
      gotAddr.push_back(imem_addr);
      gotData.push_back(imem_wdata);
      gotCyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chkResetVals(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_imem_we"},    32'(imem_we),    32'd0);
    chk({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata,      32'd0);
    chk({tag, "_core_rst"},   32'(core_rst),   32'd1);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_done"},       32'(done),       32'd0);
    chk({tag, "_err"},        32'(err),        32'd0);
  endtask

  task automatic clearCapture();
    gotAddr.delete();
    gotData.delete();
    gotCyc.delete();
  endtask

  // Offers every byte of 'stream'; gaps insert 0-3 idle cycles (with junk data) before each.
  task automatic sendBytes(input bit gaps, input int pulseAt, output bit ok);
    int waitCnt;
    ok = 1'b1;
    for (int i = 0; i < stream.size(); i++) begin
      if (gaps) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        repeat ($urandom_range(0, 3)) step();
      end
      byte_valid = 1'b1;
      byte_data  = stream[i];
      if (i == pulseAt) start = 1'b1;
      waitCnt = 0;
      while (byte_ready !== 1'b1) begin
        step();
        start = 1'b0;
        waitCnt++;
        if (waitCnt > 20) begin
          nCmp++;
          nBad++;
          $display("FAIL byte_accept: byte %0d not taken within 20 cycles", i);
          byte_valid = 1'b0;
          ok = 1'b0;
          return;
        end
      end
      step();
      start    = 1'b0;
      lastXfer = cyc;
    end
    byte_valid = 1'b0;
  endtask

  task automatic runSession(input int len, input bit fixedPl, input bit gaps, input int pulseAt,
                            input bit expErr, input int expWrites);
    bit          ok;
    int          waitCnt;
    int          expRel;
    int          n;
    logic [31:0] word;
    stream.delete();
    stream.push_back(8'(len >> 8));
    stream.push_back(8'(len));
    if (!expErr)
      for (int i = 0; i < 4 * len; i++)
        stream.push_back(fixedPl ? fixedBytes[i % 8] : 8'($urandom));
    clearCapture();

    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy",       32'(busy),       32'd1);
    chk("start_err_clear",  32'(err),        32'd0);
    chk("start_core_rst",   32'(core_rst),   32'd1);
    chk("start_done",       32'(done),       32'd0);
    chk("start_byte_ready", 32'(byte_ready), 32'd1);

    sendBytes(gaps, pulseAt, ok);
    if (!ok) return;

    if (expErr) begin
      step();
      chk("lenerr_err",        32'(err),        32'd1);
      chk("lenerr_busy",       32'(busy),       32'd0);
      chk("lenerr_core_rst",   32'(core_rst),   32'd1);
      chk("lenerr_byte_ready", 32'(byte_ready), 32'd0);
      repeat (RST_HOLD + 4) step();
      chk("lenerr_no_write",   32'(gotAddr.size()), 32'd0);
      chk("lenerr_err_sticky", 32'(err),        32'd1);
      chk("lenerr_core_held",  32'(core_rst),   32'd1);
      return;
    end

    waitCnt = 0;
    while (core_rst === 1'b1 && waitCnt < 40) begin
      step();
      waitCnt++;
    end
    if (core_rst !== 1'b0) begin
      nCmp++;
      nBad++;
      $display("FAIL release: core_rst still %b after 40 cycles (len %0d)", core_rst, len);
      return;
    end
    // The hold interval is RST_HOLD cycles, starting after the final write strobe cycle
    // (which is the cycle right after the last byte), or right after LEN_LO when len is 0.
    expRel = (len == 0) ? lastXfer + RST_HOLD : lastXfer + 1 + RST_HOLD;
    chk("release_cycle",   32'(cyc),        32'(expRel));
    chk("run_done",        32'(done),       32'd1);
    chk("run_busy",        32'(busy),       32'd0);
    chk("run_err",         32'(err),        32'd0);
    chk("run_byte_ready",  32'(byte_ready), 32'd0);
    chk("write_count",     32'(gotAddr.size()), 32'(expWrites));
    n = (gotAddr.size() < expWrites) ? gotAddr.size() : expWrites;
    for (int i = 0; i < n; i++) begin
      word = {stream[2 + 4*i], stream[3 + 4*i], stream[4 + 4*i], stream[5 + 4*i]};
      chk($sformatf("wr%0d_addr", i), 32'(gotAddr[i]), 32'(i));
      chk($sformatf("wr%0d_data", i), gotData[i], word);
    end
    if (n > 0) chk("last_write_latency", 32'(gotCyc[n-1]), 32'(lastXfer));
    if (fixedPl && n == 2) begin
      chk("fixed_word0", gotData[0], 32'h12345678);
      chk("fixed_word1", gotData[1], 32'h9ABCDEF0);
    end
  endtask

  typedef struct {
    int len;
    bit fixedPl;
    bit gaps;
    int pulseAt;
    bit expErr;
    int expWrites;
  } vecT;

  vecT vecs[8];

  initial begin
    bit ok;
    vecs[0] = '{2,   1'b1, 1'b0, -1, 1'b0, 2};
    vecs[1] = '{2,   1'b1, 1'b1, -1, 1'b0, 2};
    vecs[2] = '{0,   1'b0, 1'b0, -1, 1'b0, 0};
    vecs[3] = '{257, 1'b0, 1'b0, -1, 1'b1, 0};
    vecs[4] = '{5,   1'b0, 1'b1,  7, 1'b0, 5};
    vecs[5] = '{256, 1'b0, 1'b0, -1, 1'b0, 256};
    vecs[6] = '{1,   1'b0, 1'b1, -1, 1'b0, 1};
    vecs[7] = '{2,   1'b1, 1'b0,  5, 1'b0, 2};

    RST        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    step();
    step();
    chkResetVals("reset");
    #2 RST = 1'b0;
    step();

    for (int v = 0; v < 8; v++)
      runSession(vecs[v].len, vecs[v].fixedPl, vecs[v].gaps, vecs[v].pulseAt,
                 vecs[v].expErr, vecs[v].expWrites);

    // Asynchronous reset after six bytes, while the first word's write strobe is up.
    stream = {8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
    clearCapture();
    start = 1'b1;
    step();
    start = 1'b0;
    sendBytes(1'b0, -1, ok);
    chk("pre_rst_we", 32'(imem_we), 32'd1);
    byte_valid = 1'b1;
    byte_data  = 8'h9A;
    #2 RST = 1'b1;
    #1;
    chkResetVals("async_rst");
    step();
    #2 RST = 1'b0;
    clearCapture();
    repeat (4) step();
    chk("post_rst_no_write",   32'(gotAddr.size()), 32'd0);
    chk("post_rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("post_rst_core_rst",   32'(core_rst),   32'd1);
    byte_valid = 1'b0;
    runSession(2, 1'b1, 1'b0, -1, 1'b0, 2);

    // Random sessions against the byte-stream model.
    for (int s = 0; s < 16; s++) begin
      int len;
      bit e;
      int pa;
      len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(250, 260)) : int'($urandom_range(0, 9));
      e   = (len > CAP);
      pa  = -1;
      if (!e && len > 0 && $urandom_range(0, 1) == 1) pa = int'($urandom_range(0, 4 * len + 1));
      runSession(len, 1'b0, 1'($urandom_range(0, 1)), pa, e, e ? 0 : len);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
